usb_cmd_frame_parser: RTL and testbench
=======================================

Name: usb_cmd_frame_parser

Overview:
- Sits directly downstream of the USB CDC receive path and upstream of the command dispatcher.
- Consumes the raw byte stream (data + single-cycle valid, no backpressure) on the PHY clock domain.
- Delimits command frames, checks them, and re-emits command code, length and payload bytes with frame-level done/error strobes.
- The dispatcher acts on a command only after frame_done; it discards the buffered or partially acted payload on frame_err.

Parameters:
- MAX_LEN, 1024: largest accepted payload length in bytes; larger frames are rejected.
- TIMEOUT_CYCLES, 60000: inter-byte idle cycles inside a frame before the frame is aborted.
- HDR0, 8'hAA: first header byte.
- HDR1, 8'h55: second header byte.

Ports:
- clk  in  1  PHY clock; all logic on this single clock.
- rst  in  1  asynchronous active-high reset.
- in_data  in  8  received byte.
- in_valid  in  1  in_data valid this cycle; at most one byte per cycle, no stall possible.
- cmd_out  out  8  command code of the current frame; held until the next frame_start.
- len_out  out  16  payload length of the current frame; held until the next frame_start.
- frame_start  out  1  one-cycle pulse: header, cmd and length accepted.
- payload_data  out  8  payload byte.
- payload_valid  out  1  one-cycle pulse per payload byte.
- payload_idx  out  16  index of payload_data within the frame, 0-based.
- frame_done  out  1  one-cycle pulse: checksum matched.
- frame_err  out  1  one-cycle pulse: frame aborted.
- err_code  out  2  valid with frame_err: 0 = checksum, 1 = length > MAX_LEN, 2 = timeout.

Behaviour:
- Frame format: HDR0, HDR1, CMD, LEN_H, LEN_L, LEN payload bytes, CSUM.
- CSUM is the 8-bit sum (mod 256) of CMD, LEN_H, LEN_L and all payload bytes.
- Reset: every output is 0; state is IDLE; checksum accumulator, byte counter and timeout counter are 0.
- FSM states: IDLE, HDR, CMD, LENH, LENL, DATA, CSUM. Transitions occur only on cycles with in_valid, except timeout.
  - IDLE: byte == HDR0 -> HDR; any other byte is ignored.
  - HDR: byte == HDR1 -> CMD; byte == HDR0 -> stay in HDR (resync); any other byte -> IDLE.
  - CMD: latch cmd; accumulator = byte -> LENH.
  - LENH: latch high byte; accumulate -> LENL.
  - LENL: form length and accumulate.
    - len > MAX_LEN: frame_err with code 1 -> IDLE; no frame_start.
    - Otherwise: update cmd_out/len_out, pulse frame_start, then go to DATA if len != 0, or to CSUM if len == 0.
  - DATA: emit the byte with payload_valid and payload_idx = counter; accumulate; increment counter. The byte with counter == len-1 -> CSUM.
  - CSUM: byte == accumulator -> frame_done; otherwise frame_err with code 0. Then -> IDLE.
- Latency: every output pulse is registered and asserts exactly one cycle after the in_valid that caused it.
- The frame_done/frame_err pulse for one frame may coincide with the first byte of the next frame being accepted in IDLE.
- Timeout:
  - In any state other than IDLE, the counter increments on each cycle without in_valid and clears on in_valid.
  - When it reaches TIMEOUT_CYCLES: frame_err with code 2, then -> IDLE.
  - If in_valid arrives on the same cycle the counter hits the limit, the byte takes priority and the timeout does not fire.
- Counters are 16 bits; payload_idx never wraps because of the MAX_LEN check.
- frame_done and frame_err are never asserted together. Exactly one of them follows each frame_start.
- Asserting rst mid-frame returns to IDLE immediately; no error pulse is emitted.

Decomposition:
- Shared package holds the FSM state enum, the err_code constants (ERR_CSUM, ERR_LEN, ERR_TIMEOUT), and the HDR0/HDR1 defaults, so the dispatcher uses the same values.
- No sub-module is needed. The timeout counter may be split out as frame_timeout_ctr if it is reused by the UART receive path.

Test Plan:
- Good frame AA 55 01 00 02 10 20 33 (csum 01+00+02+10+20=33) -> frame_start with cmd_out=01, len_out=2; payload 10@idx0 and 20@idx1; frame_done; no frame_err.
- Same frame with CSUM 34 -> payload emitted, then frame_err with err_code=0; no frame_done.
- Zero-length frame AA 55 07 00 00 07 -> frame_start, no payload_valid, frame_done.
- Length 0x0401 with MAX_LEN=1024 -> frame_err with err_code=1 one cycle after LEN_L; no frame_start; next valid frame parses normally.
- Resync stream 12 AA AA 55 02 00 00 02 -> one frame_start with cmd_out=02, then frame_done.
- Timeout with TIMEOUT_CYCLES=100: stop after AA 55 01 00 05 10 -> frame_err with err_code=2 after 100 idle cycles. Also assert rst mid-frame -> all outputs 0 and no pulse.

Source files
------------

// File: rtl/usb_cmd_frame_parser_pkg.sv
// Shared definitions for the USB command frame parser and its consumers.
// Holds the parser FSM state encoding, the err_code values reported with
// frame_err, the default header bytes, and the checksum accumulate helper,
// so the dispatcher decodes exactly the same values the parser produces.
package usb_cmd_frame_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CMD  = 3'd2,
    ST_LENH = 3'd3,
    ST_LENL = 3'd4,
    ST_DATA = 3'd5,
    ST_CSUM = 3'd6
  } state_e;

  localparam logic [1:0] ERR_CSUM    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
  localparam logic [7:0] HDR1_DEFAULT = 8'h55;

  // Frame checksum is a plain mod-256 byte sum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/usb_cmd_frame_parser.sv
// USB CDC command frame parser.
// Delimits frames of the form HDR0 HDR1 CMD LEN_H LEN_L payload[LEN] CSUM from
// an unthrottled byte stream, re-emits command/length/payload and signals the
// outcome of each frame with a one-cycle frame_done or frame_err strobe.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_data, in_valid : received byte, one-cycle valid, no backpressure
//   cmd_out, len_out  : command and payload length, held until next frame_start
//   frame_start       : pulse when header, cmd and length were accepted
//   payload_data/valid/idx : payload byte, pulse, 0-based index
//   frame_done        : pulse when the checksum matched
//   frame_err, err_code : abort pulse and reason (checksum, length, timeout)
// All outputs are registered and follow the causing byte by one cycle.
module usb_cmd_frame_parser
  import usb_cmd_frame_parser_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 60000,
  parameter logic [7:0]  HDR0           = HDR0_DEFAULT,
  parameter logic [7:0]  HDR1           = HDR1_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic [7:0]  cmd_out,
  output logic [15:0] len_out,
  output logic        frame_start,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic [15:0] payload_idx,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  // Fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
  localparam logic [15:0] TMO_LIM   = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cmd_lat_q;
  logic [7:0]  lenh_q;
  logic [7:0]  acc_q;
  logic [15:0] cnt_q;
  logic [15:0] tmo_q;

  logic [7:0]  cmd_out_q;
  logic [15:0] len_out_q;
  logic        frame_start_q;
  logic [7:0]  payload_data_q;
  logic        payload_valid_q;
  logic [15:0] payload_idx_q;
  logic        frame_done_q;
  logic        frame_err_q;
  logic [1:0]  err_code_q;

  logic [15:0] len_s;
  assign len_s = {lenh_q, in_data};

  // Frame FSM with registered output strobes and timeout supervision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cmd_lat_q       <= 8'd0;
      lenh_q          <= 8'd0;
      acc_q           <= 8'd0;
      cnt_q           <= 16'd0;
      tmo_q           <= 16'd0;
      cmd_out_q       <= 8'd0;
      len_out_q       <= 16'd0;
      frame_start_q   <= 1'b0;
      payload_data_q  <= 8'd0;
      payload_valid_q <= 1'b0;
      payload_idx_q   <= 16'd0;
      frame_done_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      err_code_q      <= 2'd0;
    end else begin
      frame_start_q   <= 1'b0;
      payload_valid_q <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      if (in_valid) begin
        // A byte always wins over a timeout landing on the same cycle.
        tmo_q <= 16'd0;
        case (state_q)
          ST_IDLE: begin
            if (in_data == HDR0) state_q <= ST_HDR;
            else                 state_q <= ST_IDLE;
          end
          ST_HDR: begin
            if (in_data == HDR1)      state_q <= ST_CMD;
            else if (in_data == HDR0) state_q <= ST_HDR;  // resync on repeated HDR0
            else                      state_q <= ST_IDLE;
          end
          ST_CMD: begin
            // cmd_out must stay on the previous frame until frame_start.
            cmd_lat_q <= in_data;
            acc_q     <= in_data;
            state_q   <= ST_LENH;
          end
          ST_LENH: begin
            lenh_q  <= in_data;
            acc_q   <= csum_add(acc_q, in_data);
            state_q <= ST_LENL;
          end
          ST_LENL: begin
            if (len_s > MAX_LEN_W) begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_LEN;
              state_q     <= ST_IDLE;
            end else begin
              cmd_out_q     <= cmd_lat_q;
              len_out_q     <= len_s;
              frame_start_q <= 1'b1;
              acc_q         <= csum_add(acc_q, in_data);
              cnt_q         <= 16'd0;
              if (len_s == 16'd0) state_q <= ST_CSUM;
              else                state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            payload_data_q  <= in_data;
            payload_valid_q <= 1'b1;
            payload_idx_q   <= cnt_q;
            acc_q           <= csum_add(acc_q, in_data);
            cnt_q           <= cnt_q + 16'd1;
            if (cnt_q == len_out_q - 16'd1) state_q <= ST_CSUM;
            else                            state_q <= ST_DATA;
          end
          ST_CSUM: begin
            if (in_data == acc_q) begin
              frame_done_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CSUM;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        if (tmo_q == TMO_LIM) begin
          frame_err_q <= 1'b1;
          err_code_q  <= ERR_TIMEOUT;
          tmo_q       <= 16'd0;
          state_q     <= ST_IDLE;
        end else begin
          tmo_q <= tmo_q + 16'd1;
        end
      end else begin
        tmo_q <= 16'd0;
      end
    end
  end

  assign cmd_out       = cmd_out_q;
  assign len_out       = len_out_q;
  assign frame_start   = frame_start_q;
  assign payload_data  = payload_data_q;
  assign payload_valid = payload_valid_q;
  assign payload_idx   = payload_idx_q;
  assign frame_done    = frame_done_q;
  assign frame_err     = frame_err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_usb_cmd_frame_parser.sv
// Directed bench for usb_cmd_frame_parser. Every driven cycle pushes the
// expected output strobes for the following cycle to a scoreboard queue; the
// entry is popped and compared after the next clock edge.
module tb_usb_cmd_frame_parser;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [7:0]  cmd_out;
  logic [15:0] len_out;
  logic        frame_start;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic [15:0] payload_idx;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;

  usb_cmd_frame_parser #(
    .MAX_LEN       (1024),
    .TIMEOUT_CYCLES(100),
    .HDR0          (8'hAA),
    .HDR1          (8'h55)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .cmd_out      (cmd_out),
    .len_out      (len_out),
    .frame_start  (frame_start),
    .payload_data (payload_data),
    .payload_valid(payload_valid),
    .payload_idx  (payload_idx),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        fs;
    logic        pv;
    logic        fd;
    logic        fe;
    logic [7:0]  cmd;
    logic [15:0] len;
    logic [7:0]  pd;
    logic [15:0] pidx;
    logic [1:0]  ec;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_cmd = 8'd0;
  logic [15:0] exp_len = 16'd0;

  function automatic exp_t e_none();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t e_start(input logic [7:0] c, input logic [15:0] l);
    exp_t e;
    e = '0; e.fs = 1'b1; e.cmd = c; e.len = l;
    return e;
  endfunction

  function automatic exp_t e_pay(input logic [7:0] d, input logic [15:0] i);
    exp_t e;
    e = '0; e.pv = 1'b1; e.pd = d; e.pidx = i;
    return e;
  endfunction

  function automatic exp_t e_done();
    exp_t e;
    e = '0; e.fd = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_err(input logic [1:0] c);
    exp_t e;
    e = '0; e.fe = 1'b1; e.ec = c;
    return e;
  endfunction

  task automatic cmp(input string tag, input string name, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", tag, name, obs, expv);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s/scoreboard observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      if (e.fs) begin
        exp_cmd = e.cmd;
        exp_len = e.len;
      end
      cmp(tag, "frame_start",   {15'd0, frame_start},   {15'd0, e.fs});
      cmp(tag, "payload_valid", {15'd0, payload_valid}, {15'd0, e.pv});
      cmp(tag, "frame_done",    {15'd0, frame_done},    {15'd0, e.fd});
      cmp(tag, "frame_err",     {15'd0, frame_err},     {15'd0, e.fe});
      cmp(tag, "cmd_out",       {8'd0, cmd_out},        {8'd0, exp_cmd});
      cmp(tag, "len_out",       len_out,                exp_len);
      if (e.pv) begin
        cmp(tag, "payload_data", {8'd0, payload_data}, {8'd0, e.pd});
        cmp(tag, "payload_idx",  payload_idx,          e.pidx);
      end
      if (e.fe) cmp(tag, "err_code", {14'd0, err_code}, {14'd0, e.ec});
    end
  endtask

  // Drive one cycle from a negedge, then check after the consuming posedge.
  task automatic step(input logic v, input logic [7:0] b, input exp_t e, input string tag);
    in_valid = v;
    in_data  = b;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    check(tag);
  endtask

  task automatic sb(input logic [7:0] b, input exp_t e, input string tag);
    step(1'b1, b, e, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, e_none(), tag);
  endtask

  task automatic check_all_zero(input string tag);
    cmp(tag, "z_cmd_out",       {8'd0, cmd_out},        16'd0);
    cmp(tag, "z_len_out",       len_out,                16'd0);
    cmp(tag, "z_frame_start",   {15'd0, frame_start},   16'd0);
    cmp(tag, "z_payload_data",  {8'd0, payload_data},   16'd0);
    cmp(tag, "z_payload_valid", {15'd0, payload_valid}, 16'd0);
    cmp(tag, "z_payload_idx",   payload_idx,            16'd0);
    cmp(tag, "z_frame_done",    {15'd0, frame_done},    16'd0);
    cmp(tag, "z_frame_err",     {15'd0, frame_err},     16'd0);
    cmp(tag, "z_err_code",      {14'd0, err_code},      16'd0);
  endtask

  logic [7:0] cs;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2, "post_reset");

    // Good frame with a 2-byte payload.
    sb(8'hAA, e_none(), "good");
    sb(8'h55, e_none(), "good");
    sb(8'h01, e_none(), "good");
    sb(8'h00, e_none(), "good");
    sb(8'h02, e_start(8'h01, 16'd2), "good_start");
    sb(8'h10, e_pay(8'h10, 16'd0), "good_p0");
    sb(8'h20, e_pay(8'h20, 16'd1), "good_p1");
    sb(8'h33, e_done(), "good_done");

    // Same frame with a wrong checksum, sent back to back.
    sb(8'hAA, e_none(), "badcs");
    sb(8'h55, e_none(), "badcs");
    sb(8'h01, e_none(), "badcs");
    sb(8'h00, e_none(), "badcs");
    sb(8'h02, e_start(8'h01, 16'd2), "badcs_start");
    sb(8'h10, e_pay(8'h10, 16'd0), "badcs_p0");
    sb(8'h20, e_pay(8'h20, 16'd1), "badcs_p1");
    sb(8'h34, e_err(2'd0), "badcs_err");

    // Zero-length frame, done pulse coincides with next frame's HDR0.
    sb(8'hAA, e_none(), "zlen");
    sb(8'h55, e_none(), "zlen");
    sb(8'h07, e_none(), "zlen");
    sb(8'h00, e_none(), "zlen");
    sb(8'h00, e_start(8'h07, 16'd0), "zlen_start");
    sb(8'h07, e_done(), "zlen_done");

    // Length 0x0401 exceeds MAX_LEN: error, no frame_start.
    sb(8'hAA, e_none(), "toolong");
    sb(8'h55, e_none(), "toolong");
    sb(8'h05, e_none(), "toolong");
    sb(8'h04, e_none(), "toolong");
    sb(8'h01, e_err(2'd1), "toolong_err");

    // Next frame parses normally, with idle gaps inside it.
    sb(8'hAA, e_none(), "after");
    sb(8'h55, e_none(), "after");
    sb(8'h03, e_none(), "after");
    idle(3, "after_gap");
    sb(8'h00, e_none(), "after");
    sb(8'h01, e_start(8'h03, 16'd1), "after_start");
    idle(2, "after_gap");
    sb(8'h5A, e_pay(8'h5A, 16'd0), "after_p0");
    sb(8'h5E, e_done(), "after_done");

    // Resync: stray byte, doubled HDR0.
    sb(8'h12, e_none(), "resync");
    sb(8'hAA, e_none(), "resync");
    sb(8'hAA, e_none(), "resync");
    sb(8'h55, e_none(), "resync");
    sb(8'h02, e_none(), "resync");
    sb(8'h00, e_none(), "resync");
    sb(8'h00, e_start(8'h02, 16'd0), "resync_start");
    sb(8'h02, e_done(), "resync_done");

    // Maximum length frame (1024 bytes) is accepted.
    sb(8'hAA, e_none(), "maxlen");
    sb(8'h55, e_none(), "maxlen");
    sb(8'h09, e_none(), "maxlen");
    sb(8'h04, e_none(), "maxlen");
    sb(8'h00, e_start(8'h09, 16'h0400), "maxlen_start");
    cs = 8'h09 + 8'h04 + 8'h00;
    for (int i = 0; i < 1024; i++) begin
      sb(i[7:0], e_pay(i[7:0], i[15:0]), "maxlen_pay");
      cs = cs + i[7:0];
    end
    sb(cs, e_done(), "maxlen_done");

    // Timeout after 100 idle cycles mid-payload.
    sb(8'hAA, e_none(), "tmo");
    sb(8'h55, e_none(), "tmo");
    sb(8'h01, e_none(), "tmo");
    sb(8'h00, e_none(), "tmo");
    sb(8'h05, e_start(8'h01, 16'd5), "tmo_start");
    sb(8'h10, e_pay(8'h10, 16'd0), "tmo_p0");
    idle(99, "tmo_wait");
    step(1'b0, 8'h00, e_err(2'd2), "tmo_err");
    idle(3, "tmo_after");

    // Reset mid-frame: outputs clear, no pulse, leftover bytes ignored.
    sb(8'hAA, e_none(), "rstmid");
    sb(8'h55, e_none(), "rstmid");
    sb(8'h01, e_none(), "rstmid");
    sb(8'h00, e_none(), "rstmid");
    sb(8'h03, e_start(8'h01, 16'd3), "rstmid_start");
    sb(8'h11, e_pay(8'h11, 16'd0), "rstmid_p0");
    rst = 1'b1;
    #1;
    check_all_zero("rstmid_async");
    @(negedge clk);
    check_all_zero("rstmid_held");
    rst = 1'b0;
    exp_cmd = 8'd0;
    exp_len = 16'd0;
    sb(8'h22, e_none(), "rstmid_left");
    sb(8'h33, e_none(), "rstmid_left");
    idle(2, "rstmid_idle");
    sb(8'hAA, e_none(), "rstmid_new");
    sb(8'h55, e_none(), "rstmid_new");
    sb(8'h04, e_none(), "rstmid_new");
    sb(8'h00, e_none(), "rstmid_new");
    sb(8'h00, e_start(8'h04, 16'd0), "rstmid_new_start");
    sb(8'h04, e_done(), "rstmid_new_done");
    idle(2, "end");

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
